bus_copy_initiator: RTL and testbench

//  Bus initiator (master) for the req/ack/resp memory bus served by the memsplit bus unit.

---
 rtl/bus_copy_initiator_pkg.sv | 31 +++
 rtl/bus_copy_initiator.sv | 148 ++++++++++++++
 tb/tb_bus_copy_initiator.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_copy_initiator_pkg.sv
// Shared types and constants for the word-copy bus initiator.
package bus_copy_initiator_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [BE_W-1:0]   BUS_BE_FULL = 4'hF;
    localparam logic [ADDR_W-1:0] WORD_STRIDE = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Request payload presented on the bus alongside bus_req_o.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/bus_copy_initiator.sv
// Bus initiator copying len words from src to dst, one read then one write per word,
// with a single transaction outstanding and a read-response timeout.
module bus_copy_initiator
    import bus_copy_initiator_pkg::*;
#(
    parameter int unsigned LEN_W        = 16,
    parameter int unsigned RESP_TIMEOUT = 256
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_bi,
    input  logic [ADDR_W-1:0] dst_addr_bi,
    input  logic [LEN_W-1:0]  len_bi,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_bo,
    output logic [BE_W-1:0]   bus_be_bo,
    output logic [DATA_W-1:0] bus_wdata_bo,
    input  logic              bus_ack_i,
    input  logic              bus_resp_i,
    input  logic [DATA_W-1:0] bus_rdata_bi
);

    localparam int unsigned      TMR_W    = $clog2(RESP_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RESP_TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [DATA_W-1:0]   wbuf_q, wbuf_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                req_q, req_d;
    bus_req_t            pay_q, pay_d;

    // Next-state logic; bus outputs are decoded from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        tmr_d   = tmr_q;
        wbuf_d  = wbuf_q;
        err_d   = err_q;
        req_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pay_d   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    src_d   = word_align(src_addr_bi);
                    dst_d   = word_align(dst_addr_bi);
                    rem_d   = len_bi;
                    err_d   = 1'b0;
                    state_d = (len_bi == '0) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (bus_ack_i) begin
                    tmr_d   = '0;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                // A response arriving on the last timer cycle still wins.
                if (bus_resp_i) begin
                    wbuf_d  = bus_rdata_bi;
                    state_d = ST_WR_REQ;
                end else if (tmr_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_WR_REQ: begin
                if (bus_ack_i) begin
                    src_d   = src_q + WORD_STRIDE;
                    dst_d   = dst_q + WORD_STRIDE;
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        req_d  = (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
        busy_d = req_d || (state_d == ST_RD_WAIT);
        done_d = (state_d == ST_DONE);
        if (state_d == ST_RD_REQ) begin
            pay_d.addr = src_d;
            pay_d.be   = BUS_BE_FULL;
        end else if (state_d == ST_WR_REQ) begin
            pay_d.we    = 1'b1;
            pay_d.addr  = dst_d;
            pay_d.be    = BUS_BE_FULL;
            pay_d.wdata = wbuf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            tmr_q   <= '0;
            wbuf_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            pay_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            tmr_q   <= tmr_d;
            wbuf_q  <= wbuf_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            req_q   <= req_d;
            pay_q   <= pay_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign bus_req_o    = req_q;
    assign bus_we_o     = pay_q.we;
    assign bus_addr_bo  = pay_q.addr;
    assign bus_be_bo    = pay_q.be;
    assign bus_wdata_bo = pay_q.wdata;

endmodule

// File: tb/tb_bus_copy_initiator.sv
// Scoreboard bench for bus_copy_initiator: a memory responder, a job-level copy model
// and a monitor that checks every bus transaction and every done pulse.
module tb_bus_copy_initiator;

    localparam int unsigned LEN_W = 16;
    localparam int          TO    = 32;

    logic              clk = 1'b0;
    logic              rst_n_i = 1'b0;
    logic              start_i = 1'b0;
    logic [31:0]       src_addr_bi = '0;
    logic [31:0]       dst_addr_bi = '0;
    logic [LEN_W-1:0]  len_bi = '0;
    logic              busy_o, done_o, err_o;
    logic              bus_req_o, bus_we_o;
    logic [31:0]       bus_addr_bo, bus_wdata_bo;
    logic [3:0]        bus_be_bo;
    logic              bus_ack_i = 1'b0;
    logic              bus_resp_i = 1'b0;
    logic [31:0]       bus_rdata_bi = '0;

    bus_copy_initiator #(.LEN_W(LEN_W), .RESP_TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i),
        .src_addr_bi(src_addr_bi), .dst_addr_bi(dst_addr_bi), .len_bi(len_bi),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_bo(bus_addr_bo),
        .bus_be_bo(bus_be_bo), .bus_wdata_bo(bus_wdata_bo),
        .bus_ack_i(bus_ack_i), .bus_resp_i(bus_resp_i), .bus_rdata_bi(bus_rdata_bi)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        int t0;
        int lmin;
        int lmax;
        bit err;
        int rd;
        int wr;
    } job_t;

    txn_t        txn_q[$];
    job_t        job_q[$];
    logic [31:0] mem [256];
    logic [31:0] model_mem [256];
    int          cyc = 0;
    int          vec_cnt = 0;
    int          miscmp = 0;
    int          ack_delay = 0;
    int          resp_delay = 0;
    bit          drop_resp = 1'b0;
    int          inject_req = 0;
    int          idle_req = 0;

    function automatic int idx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: configurable ack stall, response delay, dropped responses.
    int          rsp_wait = 0;
    bit          rsp_pend = 1'b0;
    int          rsp_cnt = 0;
    logic [31:0] rsp_data = '0;
    int          inject_seen = 0;
    bit          mem_ready = 1'b0;
    always @(negedge clk) begin
        bus_resp_i = 1'b0;
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] = $urandom;
            mem_ready = 1'b1;
        end
        if (!rst_n_i) begin
            rsp_pend  = 1'b0;
            bus_ack_i = 1'b0;
            rsp_wait  = 0;
        end else begin
            if (inject_req != inject_seen) begin
                inject_seen  = inject_req;
                bus_resp_i   = 1'b1;
                bus_rdata_bi = 32'hDEAD_BEEF;
            end else if (rsp_pend) begin
                if (rsp_cnt == 0) begin
                    bus_resp_i   = 1'b1;
                    bus_rdata_bi = rsp_data;
                    rsp_pend     = 1'b0;
                end else begin
                    rsp_cnt--;
                end
            end
            if (bus_req_o) begin
                if (rsp_wait >= ack_delay) begin
                    bus_ack_i = 1'b1;
                    rsp_wait  = 0;
                    if (bus_we_o) begin
                        mem[idx(bus_addr_bo)] = bus_wdata_bo;
                    end else if (!drop_resp) begin
                        rsp_pend = 1'b1;
                        rsp_cnt  = resp_delay;
                        rsp_data = mem[idx(bus_addr_bo)];
                    end
                end else begin
                    bus_ack_i = 1'b0;
                    rsp_wait++;
                end
            end else begin
                bus_ack_i = 1'b0;
                rsp_wait  = 0;
            end
        end
    end

    // Monitor: the only process that compares and steps the counters.
    txn_t held;
    bit   stalled = 1'b0;
    bit   prev_done = 1'b0;
    int   n_rd = 0, n_wr = 0;
    int   idle_seen = 0;
    always @(negedge clk) begin
        txn_t cur, exp_t;
        job_t j;
        int   lat;
        #1;
        cur = '{we: bus_we_o, addr: bus_addr_bo, wdata: bus_wdata_bo};
        if (idle_req != idle_seen) begin
            idle_seen = idle_req;
            vec_cnt++;
            if ({bus_req_o, busy_o, done_o, err_o} != 4'b0) begin
                miscmp++;
                $display("FAIL idle_ctrl req/busy/done/err=%b required 0000", {bus_req_o, busy_o, done_o, err_o});
            end
            vec_cnt++;
            if ({bus_we_o, bus_be_bo, bus_addr_bo, bus_wdata_bo} != '0) begin
                miscmp++;
                $display("FAIL idle_payload we=%b be=%h addr=%h wdata=%h required all 0",
                         bus_we_o, bus_be_bo, bus_addr_bo, bus_wdata_bo);
            end
        end
        if (!rst_n_i) begin
            txn_q.delete();
            job_q.delete();
            n_rd = 0; n_wr = 0;
            stalled = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (bus_req_o) begin
                if (stalled) begin
                    vec_cnt++;
                    if (cur != held) begin
                        miscmp++;
                        $display("FAIL stall_stable got %h required %h", cur, held);
                    end
                end
                if (bus_ack_i) begin
                    stalled = 1'b0;
                    if (bus_we_o) n_wr++; else n_rd++;
                    vec_cnt++;
                    if (txn_q.size() == 0) begin
                        miscmp++;
                        $display("FAIL unexpected_txn we=%b addr=%h", bus_we_o, bus_addr_bo);
                    end else begin
                        exp_t = txn_q.pop_front();
                        if (bus_we_o != exp_t.we || bus_addr_bo != exp_t.addr || bus_be_bo != 4'hF ||
                            (exp_t.we && bus_wdata_bo != exp_t.wdata)) begin
                            miscmp++;
                            $display("FAIL bus_txn got we=%b addr=%h be=%h wdata=%h required we=%b addr=%h be=f wdata=%h",
                                     bus_we_o, bus_addr_bo, bus_be_bo, bus_wdata_bo, exp_t.we, exp_t.addr, exp_t.wdata);
                        end
                    end
                end else begin
                    held    = cur;
                    stalled = 1'b1;
                end
            end else begin
                stalled = 1'b0;
            end
            if (prev_done) begin
                vec_cnt++;
                if (done_o) begin
                    miscmp++;
                    $display("FAIL done_pulse_width done_o=1 required 0");
                end
            end
            if (done_o && !prev_done) begin
                vec_cnt++;
                if (job_q.size() == 0) begin
                    miscmp++;
                    $display("FAIL unexpected_done");
                end else begin
                    j   = job_q.pop_front();
                    lat = cyc - j.t0;
                    if (lat < j.lmin || lat > j.lmax) begin
                        miscmp++;
                        $display("FAIL done_latency got %0d required %0d..%0d", lat, j.lmin, j.lmax);
                    end
                    vec_cnt++;
                    if (err_o != j.err) begin
                        miscmp++;
                        $display("FAIL err_flag got %b required %b", err_o, j.err);
                    end
                    vec_cnt++;
                    if (n_rd != j.rd || n_wr != j.wr) begin
                        miscmp++;
                        $display("FAIL txn_count got rd=%0d wr=%0d required rd=%0d wr=%0d", n_rd, n_wr, j.rd, j.wr);
                    end
                    vec_cnt++;
                    if (txn_q.size() != 0) begin
                        miscmp++;
                        $display("FAIL missing_txn got %0d pending required 0", txn_q.size());
                    end
                    vec_cnt++;
                    if (mem != model_mem) begin
                        miscmp++;
                        $display("FAIL mem_image differs from copy model");
                    end
                end
                n_rd = 0; n_wr = 0;
            end
            prev_done = done_o;
        end
    end

    // Build the expected transaction list by copying word by word in the model, then start.
    task automatic post_job(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input int lmin, input int lmax, input bit drop);
        job_t        rec;
        txn_t        t;
        logic [31:0] s, d;
        model_mem = mem;
        s = src & ~32'h3;
        d = dst & ~32'h3;
        for (int i = 0; i < len; i++) begin
            t = '{we: 1'b0, addr: s, wdata: 32'h0};
            txn_q.push_back(t);
            if (drop) break;
            t = '{we: 1'b1, addr: d, wdata: model_mem[idx(s)]};
            txn_q.push_back(t);
            model_mem[idx(d)] = model_mem[idx(s)];
            s += 32'd4;
            d += 32'd4;
        end
        drop_resp = drop;
        rec.lmin  = lmin;
        rec.lmax  = lmax;
        rec.err   = drop && (len > 0);
        rec.rd    = drop ? ((len > 0) ? 1 : 0) : len;
        rec.wr    = drop ? 0 : len;
        @(negedge clk);
        rec.t0 = cyc;
        job_q.push_back(rec);
        src_addr_bi = src;
        dst_addr_bi = dst;
        len_bi      = LEN_W'(len);
        start_i     = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input bit poke);
        int n = 1;
        while (!done_o) begin
            if (n > 4000) begin
                $display("FAIL done_wait no done_o within %0d cycles", n);
                $fatal(1);
            end
            @(negedge clk);
            n++;
            start_i = poke && (n == 2);
            if (poke && n == 2) src_addr_bi = 32'h0000_0040;
        end
        start_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input int lmin, input int lmax, input bit drop, input bit poke);
        post_job(src, dst, len, lmin, lmax, drop);
        wait_done(poke);
    endtask

    initial begin
        int n, len, lo, hi;
        repeat (3) @(negedge clk);
        rst_n_i = 1'b1;
        idle_req++;
        repeat (2) @(negedge clk);

        run_job(32'h100, 32'h200, 3, 10, 10, 1'b0, 1'b0);
        run_job(32'h080, 32'h090, 0, 1, 2, 1'b0, 1'b0);
        ack_delay = 4;
        run_job(32'h010, 32'h031, 3, 1, 4000, 1'b0, 1'b0);
        ack_delay = 0;
        run_job(32'h050, 32'h060, 2, TO + 2, TO + 2, 1'b1, 1'b0);
        drop_resp = 1'b0;

        // Reset while a write is stalled on the bus, then a stray response in IDLE.
        ack_delay = 2;
        post_job(32'h300, 32'h380, 4, 1, 4000, 1'b0);
        n = 0;
        while (!(bus_req_o && bus_we_o)) begin
            if (n > 200) begin
                $display("FAIL wr_req_wait no write request seen");
                $fatal(1);
            end
            @(negedge clk);
            n++;
        end
        rst_n_i = 1'b0;
        @(negedge clk);
        idle_req++;
        @(negedge clk);
        rst_n_i = 1'b1;
        inject_req++;
        repeat (4) @(negedge clk);
        idle_req++;
        @(negedge clk);
        ack_delay = 0;
        run_job(32'h300, 32'h380, 4, 13, 13, 1'b0, 1'b0);

        run_job(32'hFFFF_FFFC, 32'h200, 2, 7, 7, 1'b0, 1'b1);

        for (int k = 0; k < 20; k++) begin
            ack_delay  = $urandom_range(0, 2);
            resp_delay = $urandom_range(0, 2);
            len        = $urandom_range(1, 6);
            lo = (ack_delay == 0 && resp_delay == 0) ? 3 * len + 1 : 1;
            hi = (ack_delay == 0 && resp_delay == 0) ? 3 * len + 1 : 4000;
            run_job($urandom, $urandom, len, lo, hi, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
